// File: rtl/key_display_mux.sv
`default_nettype none
// ============================================================================
//  Module   : key_display_mux
//  Purpose  : Debounces a 4-bit keypad code and scrolls accepted codes into a
//             four-digit, time-multiplexed, active-low seven-segment display.
//  Revision : 1.0 - initial release
// ============================================================================
module key_display_mux #(
  parameter int REFRESH_DIV   = 100000,
  parameter int STABLE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_code,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       new_key
);

  localparam int c_stab_w = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int c_rc_w   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [c_stab_w-1:0] c_stab_max = c_stab_w'(STABLE_CYCLES - 1);
  localparam logic [c_rc_w-1:0]   c_rc_max   = c_rc_w'(REFRESH_DIV - 1);

  // Hex to active-low gfedcba segment pattern.
  function automatic logic [6:0] seg_decode(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [3:0]          prev_q,      prev_d;
  logic [c_stab_w-1:0] stab_q,      stab_d;
  logic [3:0]          acc_q,       acc_d;
  logic                acc_valid_q, acc_valid_d;
  logic [15:0]         digits_q,    digits_d;   // digit3..digit0, 4 bits each
  logic [3:0]          valid_q,     valid_d;
  logic                new_key_q,   new_key_d;
  logic [c_rc_w-1:0]   rc_q,        rc_d;
  logic [1:0]          idx_q,       idx_d;
  logic [3:0]          an_q,        an_d;
  logic [6:0]          seg_q,       seg_d;

  logic                accept;
  logic                rc_wrap;
  logic [3:0]          cur_digit;

  // Next-state logic for debounce, digit shift register and display scan.
  always_comb begin
    prev_d      = key_code;
    stab_d      = stab_q;
    acc_d       = acc_q;
    acc_valid_d = acc_valid_q;
    digits_d    = digits_q;
    valid_d     = valid_q;
    new_key_d   = 1'b0;
    rc_d        = rc_q;
    idx_d       = idx_q;
    an_d        = an_q;
    seg_d       = seg_q;
    cur_digit   = digits_q[{idx_q, 2'b00} +: 4];

    // Any change restarts the window; saturation keeps a long-held code from
    // ever looking like a fresh stable period.
    if (key_code != prev_q) begin
      stab_d = '0;
    end else if (stab_q != c_stab_max) begin
      stab_d = stab_q + 1'b1;
    end

    // A code that equals the last accepted one is only taken again after a
    // different code has been accepted in between.
    accept = (stab_q == c_stab_max) && (!acc_valid_q || (prev_q != acc_q));
    if (accept) begin
      digits_d    = {digits_q[11:0], prev_q};
      valid_d     = {valid_q[2:0], 1'b1};
      acc_d       = prev_q;
      acc_valid_d = 1'b1;
      new_key_d   = 1'b1;
    end

    rc_wrap = (rc_q == c_rc_max);
    if (rc_wrap) begin
      rc_d  = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      rc_d  = rc_q + 1'b1;
    end

    // Enables and segments are registered together from the current index so
    // they can never disagree about which digit is lit.
    an_d  = ~(4'b0001 << idx_q);
    seg_d = valid_q[idx_q] ? seg_decode(cur_digit) : 7'h7F;
  end

  // State registers; reset wins over acceptance and refresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q      <= 4'h0;
      stab_q      <= '0;
      acc_q       <= 4'h0;
      acc_valid_q <= 1'b0;
      digits_q    <= 16'h0000;
      valid_q     <= 4'h0;
      new_key_q   <= 1'b0;
      rc_q        <= '0;
      idx_q       <= 2'd0;
      an_q        <= 4'b1110;
      seg_q       <= 7'h7F;
    end else begin
      prev_q      <= prev_d;
      stab_q      <= stab_d;
      acc_q       <= acc_d;
      acc_valid_q <= acc_valid_d;
      digits_q    <= digits_d;
      valid_q     <= valid_d;
      new_key_q   <= new_key_d;
      rc_q        <= rc_d;
      idx_q       <= idx_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign seg     = seg_q;
  assign an      = an_q;
  assign dp      = 1'b1;
  assign new_key = new_key_q;

endmodule
`default_nettype wire

// File: tb/tb_key_display_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_display_mux
//  Purpose  : Self-checking bench for key_display_mux with a behavioural
//             reference model (sample-history debounce, cycle-count scan).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_key_display_mux;

  localparam int R = 4;
  localparam int S = 3;

  logic       clk;
  logic       rst;
  logic [3:0] key_code;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       new_key;

  key_display_mux #(
    .REFRESH_DIV  (R),
    .STABLE_CYCLES(S)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .key_code(key_code),
    .seg     (seg),
    .an      (an),
    .dp      (dp),
    .new_key (new_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         hist[$];      // key samples since reset (reset counts as a 0)
  logic [3:0] m_dig[4];
  logic       m_val[4];
  logic [3:0] m_acc;
  logic       m_accv;
  int         cyc;          // non-reset edges since last reset
  logic       exp_new;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  int         nk_cnt;
  int         last_nk_cyc;

  function automatic logic [6:0] seg_of(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic model_edge(input logic r, input logic [3:0] k);
    int  id;
    bit  stable;
    if (r) begin
      hist.delete();
      hist.push_back(0);
      for (int i = 0; i < 4; i++) begin
        m_dig[i] = 4'h0;
        m_val[i] = 1'b0;
      end
      m_acc   = 4'h0;
      m_accv  = 1'b0;
      cyc     = 0;
      exp_new = 1'b0;
      exp_an  = 4'b1110;
      exp_seg = 7'h7F;
    end else begin
      id      = (cyc / R) % 4;
      exp_an  = 4'hF;
      exp_an[id] = 1'b0;
      exp_seg = m_val[id] ? seg_of(m_dig[id]) : 7'h7F;
      // accepted when the last S samples agree and differ from the last accept
      stable = (hist.size() >= S);
      if (stable)
        for (int j = 0; j < S; j++)
          if (hist[hist.size()-1-j] != hist[hist.size()-1]) stable = 1'b0;
      exp_new = stable && (!m_accv || (4'(hist[hist.size()-1]) != m_acc));
      if (exp_new) begin
        for (int i = 3; i > 0; i--) begin
          m_dig[i] = m_dig[i-1];
          m_val[i] = m_val[i-1];
        end
        m_dig[0] = 4'(hist[hist.size()-1]);
        m_val[0] = 1'b1;
        m_acc    = m_dig[0];
        m_accv   = 1'b1;
      end
      hist.push_back(int'(k));
      if (hist.size() > S) void'(hist.pop_front());
      cyc++;
    end
  endtask

  task automatic tick(input logic r, input logic [3:0] k);
    rst      = r;
    key_code = k;
    @(posedge clk);
    model_edge(r, k);
    #1;
    chk("new_key", {31'd0, new_key}, {31'd0, exp_new});
    chk("an",      {28'd0, an},      {28'd0, exp_an});
    chk("seg",     {25'd0, seg},     {25'd0, exp_seg});
    chk("dp",      {31'd0, dp},      32'd1);
    if (new_key) begin
      nk_cnt++;
      last_nk_cyc = cyc;
    end
  endtask

  // Hold one key for a full scan and compare each lit digit with constants.
  task automatic scan(input logic [3:0] k, input logic [6:0] e0, input logic [6:0] e1,
                      input logic [6:0] e2, input logic [6:0] e3);
    for (int i = 0; i < 4 * R; i++) begin
      tick(1'b0, k);
      case (an)
        4'b1110: chk("scan_d0", {25'd0, seg}, {25'd0, e0});
        4'b1101: chk("scan_d1", {25'd0, seg}, {25'd0, e1});
        4'b1011: chk("scan_d2", {25'd0, seg}, {25'd0, e2});
        4'b0111: chk("scan_d3", {25'd0, seg}, {25'd0, e3});
        default: chk("scan_an", {28'd0, an}, 32'hE);
      endcase
    end
  endtask

  initial begin
    logic [3:0] k;
    int         hold;
    rst = 1'b1;
    key_code = 4'h0;
    nk_cnt = 0;
    last_nk_cyc = 0;

    // Reset state, then a scan with a never-stable key keeps every digit blank
    tick(1'b1, 4'h0);
    tick(1'b1, 4'h0);
    chk("rst_an",  {28'd0, an},  32'hE);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    for (int i = 0; i < 4 * R; i++) begin
      tick(1'b0, (i % 2 == 0) ? 4'h4 : 4'h5);
      chk("blank", {25'd0, seg}, 32'h7F);
    end

    // First accept of 0 after reset
    tick(1'b1, 4'h0);
    tick(1'b1, 4'h0);
    nk_cnt = 0;
    tick(1'b0, 4'h0);
    tick(1'b0, 4'h0);
    chk("first_early", nk_cnt, 0);
    tick(1'b0, 4'h0);
    chk("first_pulse", {31'd0, new_key}, 32'd1);
    scan(4'h0, 7'h40, 7'h7F, 7'h7F, 7'h7F);
    chk("first_once", nk_cnt, 1);

    // Shift order 1, 2, 3, A
    nk_cnt = 0;
    for (int i = 0; i < 4; i++) tick(1'b0, 4'h1);
    for (int i = 0; i < 4; i++) tick(1'b0, 4'h2);
    for (int i = 0; i < 4; i++) tick(1'b0, 4'h3);
    for (int i = 0; i < 4; i++) tick(1'b0, 4'hA);
    chk("shift_cnt", nk_cnt, 4);
    scan(4'hA, 7'h08, 7'h30, 7'h24, 7'h79);

    // Glitch rejection
    for (int i = 0; i < 5; i++) tick(1'b0, 4'h5);
    nk_cnt = 0;
    tick(1'b0, 4'h9);
    tick(1'b0, 4'h9);
    for (int i = 0; i < 10; i++) tick(1'b0, 4'h5);
    chk("glitch_nk", nk_cnt, 0);
    scan(4'h5, 7'h12, 7'h08, 7'h30, 7'h24);

    // Reset on the edge where acceptance would have happened
    nk_cnt = 0;
    for (int i = 0; i < 3; i++) tick(1'b0, 4'h7);
    tick(1'b1, 4'h7);
    chk("midrst_nk",  nk_cnt, 0);
    chk("midrst_seg", {25'd0, seg}, 32'h7F);
    for (int i = 0; i < 3; i++) tick(1'b0, 4'h7);
    chk("midrst_early", nk_cnt, 0);
    tick(1'b0, 4'h7);
    chk("midrst_acc", nk_cnt, 1);

    // Accept F on an rc wrap edge
    while (cyc % R != 0) tick(1'b0, 4'h7);
    nk_cnt = 0;
    for (int i = 0; i < 4; i++) tick(1'b0, 4'hF);
    chk("wrap_nk",    nk_cnt, 1);
    chk("wrap_align", last_nk_cyc % R, 0);
    scan(4'hF, 7'h0E, 7'h78, 7'h7F, 7'h7F);

    // Randomized runs of random length with occasional resets
    for (int n = 0; n < 250; n++) begin
      k    = 4'($urandom_range(0, 15));
      hold = $urandom_range(1, 6);
      if ($urandom_range(0, 39) == 0) tick(1'b1, k);
      for (int h = 0; h < hold; h++) tick(1'b0, k);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_display_mux.md
KEY_DISPLAY_MUX -- requirements
Module: key_display_mux

Interface
REQ-001 SHALL provide parameter REFRESH_DIV, default 100000: clk cycles each digit is lit (1 ms at 100 MHz); legal values are 2 or more.
REQ-002 SHALL provide parameter STABLE_CYCLES, default 1000000: consecutive identical key_code samples required before a code is accepted; legal values are 2 or more.
REQ-003 SHALL provide port clk, input, 1: the single clock; all logic changes on its rising edge.
REQ-004 SHALL provide port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL provide port key_code, input, 4: hex code from the upstream keypad decoder; it may change on any cycle.
REQ-006 SHALL provide port seg, output, 7: segment drive, active-low; seg[6:0] = g,f,e,d,c,b,a.
REQ-007 SHALL provide port an, output, 4: digit enables, active-low; an[0] is the rightmost digit.
REQ-008 SHALL provide port dp, output, 1: decimal point, held at 1 (off).
REQ-009 SHALL provide port new_key, output, 1: one-cycle pulse on the cycle a code is accepted.

Function
REQ-010 SHALL sample key_code into register prev every cycle.
REQ-011 SHALL clear stability counter stab to 0 when key_code != prev; otherwise stab increments, saturating at STABLE_CYCLES-1.
REQ-012 SHALL accept prev on the first cycle that stab == STABLE_CYCLES-1 and (acc_valid == 0 or prev != acc); saturation ensures one acceptance per stable period.
REQ-013 On acceptance SHALL shift left: digit3<=digit2, digit2<=digit1, digit1<=digit0, digit0<=prev; valid bits shift identically with valid0<=1; acc<=prev; acc_valid<=1; new_key<=1 for exactly one cycle.
REQ-014 SHALL NOT re-accept an unchanged code; a repeat of the same key is accepted only after a different code has first been accepted.
REQ-015 SHALL run refresh counter rc from 0 to REFRESH_DIV-1 and then wrap; on wrap, digit index idx (2 bits) increments mod 4 (3->0).
REQ-016 SHALL register an and seg together: an = 0 at bit idx, 1 at other bits; seg = decode of digit[idx] if valid[idx] is set, else 7'h7F (blank). Both update one cycle after idx changes.
REQ-017 Decode table SHALL be (hex, gfedcba active-low): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
REQ-018 Simultaneous acceptance and refresh wrap SHALL both take effect; the newly shifted digits appear at the next an/seg registration.
REQ-019 SHALL accept a key_code change during a stability window only after a full new STABLE_CYCLES window; glitches shorter than this SHALL never be accepted.

Reset
REQ-020 While rst=1 at a clk edge, the block SHALL set: stab, rc, idx = 0; digits = 0; valid = 0; acc = 0; acc_valid = 0; prev = 0; new_key = 0; an = 4'b1110; seg = 7'h7F; dp = 1.
REQ-021 rst asserted mid-operation SHALL take priority over acceptance and refresh on that edge; any partial stability count SHALL be discarded.
REQ-022 After rst is released, the first accepted code SHALL be accepted even if it equals 0.

Verification (REFRESH_DIV=4, STABLE_CYCLES=3)
REQ-023 Reset check: hold rst for 2 cycles -> an=1110, seg=7F, new_key=0, dp=1; all digits stay blank through a full 16-cycle scan.
REQ-024 First accept: after reset, hold key_code=0 -> new_key pulses once, 3 cycles after the first stable sample. The scan then shows seg=40 when an=1110 and seg=7F on the other three digits.
REQ-025 Shift order: accept 1, 2, 3, A in turn -> over one scan, an=1110/1101/1011/0111 show seg=08/30/24/79 respectively.
REQ-026 Glitch reject: stable code 5, then 2-cycle pulse to 9, then back to 5 -> no new_key and the digits are unchanged; hold 5 for 10 more cycles -> still no new_key.
REQ-027 Mid-operation reset: assert rst on the cycle stab reaches 2 with a new code -> no new_key and all digits blank; the same code held afterward is accepted 3 cycles after the first stable sample.
REQ-028 Wrap/simultaneity: schedule acceptance of F on an rc wrap cycle -> idx advances, digit0=F, and seg=0E when an=1110 on the next scan.
